// File: rtl/bit_deserializer.sv
// Serial-to-parallel packer: MSB-first WIDTH-bit words, REC_LEN-word records, DEPTH-entry output FIFO.
// Optional macro BIT_DESERIALIZER_OVF_CNT_EN enables the saturating dropped-word counter on ovf_cnt.
module bit_deserializer #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 4,
    parameter int REC_LEN = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             bit_en,
    input  logic             bit_in,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last,
    output logic             busy,
    output logic             done,
    output logic [15:0]      ovf_cnt
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BW = $clog2(WIDTH);
    localparam int RW = (REC_LEN > 1) ? $clog2(REC_LEN) : 1;

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_FLUSH, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [WIDTH-2:0] shreg_q, shreg_d;
    logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [RW-1:0]   word_cnt_q, word_cnt_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic [WIDTH:0]  mem_q [DEPTH];
    logic [WIDTH:0]  mem_d [DEPTH];

    logic [WIDTH-1:0] word;
    logic             word_done;
    logic             word_last;
    logic             full;
    logic             pop;
    logic             push_ok;

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        word_cnt_d = word_cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;

        word      = {shreg_q, bit_in};
        word_done = (state_q == S_CAPTURE) && bit_en && (bit_cnt_q == BW'(WIDTH - 1));
        word_last = (word_cnt_q == RW'(REC_LEN - 1));
        full      = (count_q == (AW + 1)'(DEPTH));
        pop       = (count_q != '0) && m_ready;
        // A pop in the same cycle frees the slot a full FIFO needs.
        push_ok   = word_done && (!full || pop);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_CAPTURE;
                    shreg_d    = '0;
                    bit_cnt_d  = '0;
                    word_cnt_d = '0;
                end
            end
            S_CAPTURE: begin
                if (bit_en) begin
                    shreg_d = word[WIDTH-2:0];
                    if (bit_cnt_q == BW'(WIDTH - 1)) begin
                        bit_cnt_d = '0;
                        if (word_last) begin
                            word_cnt_d = '0;
                            state_d    = S_FLUSH;
                        end else begin
                            word_cnt_d = word_cnt_q + 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            S_FLUSH: begin
                if (count_q == '0) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
            always_comb begin
                mem_d[gi] = mem_q[gi];
                if (push_ok && (wr_ptr_q == AW'(gi))) begin
                    mem_d[gi] = {word_last, word};
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    mem_q[gi] <= '0;
                end else begin
                    mem_q[gi] <= mem_d[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            word_cnt_q <= word_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

`ifdef BIT_DESERIALIZER_OVF_CNT_EN
    logic [15:0] ovf_cnt_q, ovf_cnt_d;

    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (word_done && !push_ok && (ovf_cnt_q != 16'hFFFF)) begin
            ovf_cnt_d = ovf_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_cnt_q <= '0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign ovf_cnt = ovf_cnt_q;
`else
    assign ovf_cnt = 16'h0000;
`endif

    // Head is driven straight from FIFO registers; gated so an empty FIFO reads as zero.
    assign m_valid = (count_q != '0);
    assign m_data  = m_valid ? mem_q[rd_ptr_q][WIDTH-1:0] : '0;
    assign m_last  = m_valid & mem_q[rd_ptr_q][WIDTH];
    assign busy    = (state_q == S_CAPTURE) || (state_q == S_FLUSH);
    assign done    = (state_q == S_DONE);
endmodule

// File: tb/tb_bit_deserializer.sv
// Scoreboard bench: dut 0 uses REC_LEN=4, dut 1 uses REC_LEN=6 for the overflow scenarios.
module tb_bit_deserializer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start   [2];
    logic       bit_en  [2];
    logic       bit_in  [2];
    logic       m_ready [2];
    logic [7:0] m_data  [2];
    logic       m_valid [2];
    logic       m_last  [2];
    logic       busy    [2];
    logic       done    [2];
    logic [15:0] ovf_cnt [2];

    logic [8:0] exp_q0 [$];
    logic [8:0] exp_q1 [$];
    int n_cmp = 0;
    int n_bad = 0;

`ifdef BIT_DESERIALIZER_OVF_CNT_EN
    localparam logic [15:0] OVF_AFTER_DROP = 16'd2;
`else
    localparam logic [15:0] OVF_AFTER_DROP = 16'd0;
`endif

    always #5 clk = ~clk;

    bit_deserializer #(.WIDTH(8), .DEPTH(4), .REC_LEN(4)) dut0 (
        .clk(clk), .rst(rst), .start(start[0]), .bit_en(bit_en[0]), .bit_in(bit_in[0]),
        .m_data(m_data[0]), .m_valid(m_valid[0]), .m_ready(m_ready[0]), .m_last(m_last[0]),
        .busy(busy[0]), .done(done[0]), .ovf_cnt(ovf_cnt[0])
    );

    bit_deserializer #(.WIDTH(8), .DEPTH(4), .REC_LEN(6)) dut1 (
        .clk(clk), .rst(rst), .start(start[1]), .bit_en(bit_en[1]), .bit_in(bit_in[1]),
        .m_data(m_data[1]), .m_valid(m_valid[1]), .m_ready(m_ready[1]), .m_last(m_last[1]),
        .busy(busy[1]), .done(done[1]), .ovf_cnt(ovf_cnt[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_word(input int s, input logic last, input logic [7:0] data);
        if (s == 0) exp_q0.push_back({last, data});
        else        exp_q1.push_back({last, data});
    endtask

    function automatic int qsize(input int s);
        return (s == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    // Monitor: a transfer seen here completes on the following rising edge.
    task automatic mon(input int s);
        logic [8:0] a;
        logic [8:0] e;
        if (m_valid[s] && m_ready[s]) begin
            a = {m_last[s], m_data[s]};
            n_cmp++;
            if (qsize(s) == 0) begin
                n_bad++;
                $display("FAIL dut%0d_unexpected_word: got last=%b data=%h required none", s, a[8], a[7:0]);
            end else begin
                if (s == 0) e = exp_q0.pop_front();
                else        e = exp_q1.pop_front();
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL dut%0d_word: got last=%b data=%h required last=%b data=%h",
                             s, a[8], a[7:0], e[8], e[7:0]);
                end else begin
                    $display("dut%0d word data=%h last=%b", s, a[7:0], a[8]);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon(0);
            mon(1);
        end
    end

    task automatic start_rec(input int s);
        start[s] = 1'b1;
        tick();
        start[s] = 1'b0;
        check($sformatf("dut%0d_busy_after_start", s), busy[s], 1);
    endtask

    task automatic send_byte(input int s, input logic [7:0] b, input bit gap,
                             input bit rdy_last, input bit chk_lat);
        for (int i = 7; i >= 0; i--) begin
            bit_en[s] = 1'b1;
            bit_in[s] = b[i];
            if (i == 0 && rdy_last) m_ready[s] = 1'b1;
            tick();
            if (chk_lat && i == 1) check($sformatf("dut%0d_valid_before_8th_%h", s, b), m_valid[s], 0);
            if (chk_lat && i == 0) check($sformatf("dut%0d_valid_after_8th_%h", s, b), m_valid[s], 1);
            if (gap) begin
                bit_en[s] = 1'b0;
                bit_in[s] = ~b[i];
                tick();
            end
        end
        bit_en[s] = 1'b0;
    endtask

    task automatic wait_done(input int s, input string tag);
        int i;
        i = 0;
        while (!done[s] && i < 200) begin
            tick();
            i++;
        end
        check({tag, "_done_seen"}, done[s], 1);
        check({tag, "_busy_in_done"}, busy[s], 0);
        check({tag, "_words_left"}, qsize(s), 0);
        tick();
        check({tag, "_done_one_cycle"}, done[s], 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] basic [4];
        logic [7:0] six   [6];
        basic = '{8'hA5, 8'h3C, 8'hFF, 8'h01};
        for (int s = 0; s < 2; s++) begin
            start[s] = 1'b0; bit_en[s] = 1'b0; bit_in[s] = 1'b0; m_ready[s] = 1'b0;
        end

        // Reset state
        rst = 1'b1;
        tick(); tick(); tick();
        for (int s = 0; s < 2; s++) begin
            check($sformatf("rst_m_valid%0d", s), m_valid[s], 0);
            check($sformatf("rst_m_last%0d", s), m_last[s], 0);
            check($sformatf("rst_m_data%0d", s), m_data[s], 0);
            check($sformatf("rst_busy%0d", s), busy[s], 0);
            check($sformatf("rst_done%0d", s), done[s], 0);
            check($sformatf("rst_ovf%0d", s), ovf_cnt[s], 0);
        end
        rst = 1'b0;
        tick();

        // Basic pack
        m_ready[0] = 1'b1;
        start_rec(0);
        for (int w = 0; w < 4; w++) expect_word(0, w == 3, basic[w]);
        for (int w = 0; w < 4; w++) send_byte(0, basic[w], 1'b0, 1'b0, 1'b1);
        wait_done(0, "basic");
        check("basic_ovf", ovf_cnt[0], 0);

        // Gapped bit_en
        start_rec(0);
        for (int w = 0; w < 4; w++) expect_word(0, w == 3, basic[w]);
        for (int w = 0; w < 4; w++) send_byte(0, basic[w], 1'b1, 1'b0, 1'b1);
        wait_done(0, "gapped");

        // Backpressure: exactly DEPTH words fit
        m_ready[0] = 1'b0;
        start_rec(0);
        basic = '{8'h12, 8'h34, 8'h56, 8'h78};
        for (int w = 0; w < 4; w++) expect_word(0, w == 3, basic[w]);
        for (int w = 0; w < 4; w++) send_byte(0, basic[w], 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("bp_hold_valid", m_valid[0], 1);
            check("bp_hold_data", m_data[0], 8'h12);
            check("bp_hold_last", m_last[0], 0);
        end
        check("bp_busy_flush", busy[0], 1);
        m_ready[0] = 1'b1;
        wait_done(0, "bp");
        check("bp_ovf", ovf_cnt[0], 0);

        // Overflow on REC_LEN=6: words 5,6 dropped, no m_last
        six = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        m_ready[1] = 1'b0;
        start_rec(1);
        for (int w = 0; w < 4; w++) expect_word(1, 1'b0, six[w]);
        for (int w = 0; w < 6; w++) send_byte(1, six[w], 1'b0, 1'b0, 1'b0);
        check("ovf_count", ovf_cnt[1], OVF_AFTER_DROP);
        check("ovf_full_valid", m_valid[1], 1);
        m_ready[1] = 1'b1;
        wait_done(1, "ovf");

        // Full FIFO with simultaneous pop on the cycle word 5 completes
        six = '{8'h81, 8'h82, 8'h83, 8'h84, 8'h85, 8'h86};
        m_ready[1] = 1'b0;
        start_rec(1);
        for (int w = 0; w < 6; w++) expect_word(1, w == 5, six[w]);
        for (int w = 0; w < 4; w++) send_byte(1, six[w], 1'b0, 1'b0, 1'b0);
        send_byte(1, six[4], 1'b0, 1'b1, 1'b0);
        send_byte(1, six[5], 1'b0, 1'b0, 1'b0);
        check("simpop_ovf", ovf_cnt[1], OVF_AFTER_DROP);
        wait_done(1, "simpop");

        // Ignored start during capture, then rst after 13 bits
        m_ready[0] = 1'b1;
        start_rec(0);
        expect_word(0, 1'b0, 8'hC3);
        start[0] = 1'b1;
        send_byte(0, 8'hC3, 1'b0, 1'b0, 1'b0);
        start[0] = 1'b0;
        basic = '{8'h9E, 8'h00, 8'h00, 8'h00};
        for (int i = 7; i >= 3; i--) begin
            bit_en[0] = 1'b1;
            bit_in[0] = basic[0][i];
            tick();
        end
        bit_en[0] = 1'b0;
        rst = 1'b1;
        tick();
        check("midrst_m_valid", m_valid[0], 0);
        check("midrst_m_data", m_data[0], 0);
        check("midrst_m_last", m_last[0], 0);
        check("midrst_busy", busy[0], 0);
        check("midrst_done", done[0], 0);
        check("midrst_ovf1", ovf_cnt[1], 0);
        check("midrst_words_left", qsize(0), 0);
        rst = 1'b0;
        tick();
        start_rec(0);
        basic = '{8'h5A, 8'hF0, 8'h0F, 8'h81};
        for (int w = 0; w < 4; w++) expect_word(0, w == 3, basic[w]);
        send_byte(0, basic[0], 1'b0, 1'b0, 1'b1);
        start[0] = 1'b1;
        send_byte(0, basic[1], 1'b1, 1'b0, 1'b0);
        start[0] = 1'b0;
        send_byte(0, basic[2], 1'b0, 1'b0, 1'b1);
        send_byte(0, basic[3], 1'b0, 1'b0, 1'b1);
        wait_done(0, "post_rst");

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
